// File: rtl/pulse_fast2slow_hs.sv
// Fast-to-slow event pulse transfer over a 4-phase req/ack level handshake.
// Events arriving while a transfer is in flight are queued in a saturating
// pending counter. Each accepted event yields one clk_slow-cycle dout_pulse.
module pulse_fast2slow_hs #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             clk_slow,
  input  logic             din_pulse,
  input  logic             clr_ovf,
  output logic             dout_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  // Bit 0 is set only in WAIT_ACK, so req_f comes straight from a single flop.
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] WAIT_ACK = 2'b01;
  localparam logic [1:0] WAIT_CLR = 2'b10;

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             launch, drop;
  logic             req_f, req_s, req_s_d_q, ack_f;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] req_sync_q;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync_q;

  assign req_f = state_q[0];
  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_f = ack_sync_q[SYNC_STAGES-1];

  // Fast-side next state: launch decision, pending queue, sticky overflow, handshake FSM.
  always_comb begin
    launch = (state_q == IDLE) && ((pend_q != '0) || din_pulse);
    // A drop only happens when the queue is full and nothing leaves this cycle.
    drop   = din_pulse && !launch && (pend_q == PEND_MAX);

    pend_d = pend_q;
    if (din_pulse && !launch && !drop) begin
      pend_d = pend_q + PEND_ONE;
    end else if (launch && !din_pulse) begin
      pend_d = pend_q - PEND_ONE;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      IDLE:     if (launch) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_f)  state_d = WAIT_CLR;
      WAIT_CLR: if (!ack_f) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Fast-domain state registers.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ack return path: req_s resynchronised into clk_fast.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_s};
    end
  end

  // Request path into clk_slow plus the edge-detect flop.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      req_s_d_q  <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_f};
      req_s_d_q  <= req_s;
    end
  end

  assign dout_pulse = req_s & ~req_s_d_q;
  assign busy       = (state_q != IDLE) || (pend_q != '0);
  assign pending    = pend_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pulse_fast2slow_hs.sv
// Bench for pulse_fast2slow_hs: two instances (CNT_W=4 and CNT_W=2) share stimulus
// and are checked every cycle against a delay-line reference model, plus directed
// literal expectations for reset, single event, burst, overflow, simultaneity and abort.
module tb_pulse_fast2slow_hs;

  localparam int S = 2;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic rst_n    = 1'b1;
  logic din      = 1'b0;
  logic clr      = 1'b0;
  int   slow_half = 50;

  logic       dout0, busy0, ovf0;
  logic [3:0] pend0;
  logic       dout1, busy1, ovf1;
  logic [1:0] pend1;

  pulse_fast2slow_hs #(.CNT_W(4), .SYNC_STAGES(S)) dut0 (
    .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .din_pulse(din),
    .clr_ovf(clr), .dout_pulse(dout0), .busy(busy0), .pending(pend0), .overflow(ovf0)
  );

  pulse_fast2slow_hs #(.CNT_W(2), .SYNC_STAGES(S)) dut1 (
    .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .din_pulse(din),
    .clr_ovf(clr), .dout_pulse(dout1), .busy(busy1), .pending(pend1), .overflow(ovf1)
  );

  // Fast posedges at 5 mod 10, stimulus at 0 mod 10; slow edges stay at 2/7 mod 10.
  always #5 clk_fast = ~clk_fast;
  initial begin
    #2;
    forever #(slow_half) clk_slow = ~clk_slow;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int pc[2];
  int peak[2];

  // Reference model: queue depth arithmetic, transfer phase, and level histories.
  int     max_p[2];
  int     m_pend[2];
  bit     m_ovf[2];
  int     m_phase[2];  // 0 no transfer, 1 request up, 2 waiting for ack to fall
  bit     m_req[2];
  bit     m_dout[2];
  bit [7:0] sh[2];     // request level as seen at successive slow edges
  bit [7:0] fh[2];     // slow-side request as seen at successive fast edges

  initial begin
    max_p[0] = 15;
    max_p[1] = 3;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_fast or negedge rst_n) begin
    bit ack, launch, drop;
    int nxt;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0; m_ovf[k] = 1'b0; m_phase[k] = 0; m_req[k] = 1'b0; fh[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        ack    = fh[k][S-1];
        fh[k]  = {fh[k][6:0], sh[k][S-1]};
        launch = (m_phase[k] == 0) && (m_pend[k] != 0 || din);
        nxt    = m_pend[k] + (din ? 1 : 0) - (launch ? 1 : 0);
        drop   = nxt > max_p[k];
        m_pend[k] = drop ? max_p[k] : nxt;
        if (drop) m_ovf[k] = 1'b1;
        else if (clr) m_ovf[k] = 1'b0;
        if (m_phase[k] == 0 && launch) m_phase[k] = 1;
        else if (m_phase[k] == 1 && ack) m_phase[k] = 2;
        else if (m_phase[k] == 2 && !ack) m_phase[k] = 0;
        m_req[k] = (m_phase[k] == 1);
      end
    end
  end

  always @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        sh[k] = '0; m_dout[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        sh[k]     = {sh[k][6:0], m_req[k]};
        m_dout[k] = sh[k][S-1] & ~sh[k][S];
      end
    end
  end

  // Fast-domain compare, a few ns after each fast edge.
  always @(posedge clk_fast) begin
    #3;
    if (chk_en) begin
      chk("pending0", int'(pend0), m_pend[0]);
      chk("overflow0", int'(ovf0), int'(m_ovf[0]));
      chk("busy0", int'(busy0), int'(m_phase[0] != 0 || m_pend[0] != 0));
      chk("pending1", int'(pend1), m_pend[1]);
      chk("overflow1", int'(ovf1), int'(m_ovf[1]));
      chk("busy1", int'(busy1), int'(m_phase[1] != 0 || m_pend[1] != 0));
      if (int'(pend0) > peak[0]) peak[0] = int'(pend0);
      if (int'(pend1) > peak[1]) peak[1] = int'(pend1);
    end
  end

  // Slow-domain compare in the middle of each slow cycle.
  always @(negedge clk_slow) begin
    if (chk_en) begin
      chk("dout0", int'(dout0), int'(m_dout[0]));
      chk("dout1", int'(dout1), int'(m_dout[1]));
      if (dout0) pc[0]++;
      if (dout1) pc[1]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_fast);
  endtask

  task automatic pulse_din(input int n);
    for (int i = 0; i < n; i++) begin
      din = 1'b1;
      @(negedge clk_fast);
    end
    din = 1'b0;
  endtask

  int base0, base1, pct;
  bit found;
  int halves[4];
  int probs[4];

  initial begin
    halves = '{35, 15, 5, 50};
    probs  = '{20, 60, 5, 90};
    @(negedge clk_fast);

    // T1 reset
    rst_n  = 1'b0;
    chk_en = 1'b1;
    cyc(3);
    chk("t1_pend0", int'(pend0), 0);
    chk("t1_busy0", int'(busy0), 0);
    chk("t1_ovf0", int'(ovf0), 0);
    chk("t1_dout0", int'(dout0), 0);
    rst_n = 1'b1;
    cyc(5);
    chk("t1_rel_busy0", int'(busy0), 0);
    chk("t1_rel_pend1", int'(pend1), 0);

    // T2 single event at 100MHz/10MHz
    base0 = pc[0]; base1 = pc[1];
    pulse_din(1);
    cyc(150);
    chk("t2_pulses0", pc[0] - base0, 1);
    chk("t2_pulses1", pc[1] - base1, 1);
    chk("t2_busy0", int'(busy0), 0);

    // T3 burst of 5
    base0 = pc[0]; base1 = pc[1]; peak[0] = 0; peak[1] = 0;
    pulse_din(5);
    chk("t3_peak0", peak[0], 4);
    cyc(500);
    chk("t3_pulses0", pc[0] - base0, 5);
    chk("t3_pend0", int'(pend0), 0);
    chk("t3_ovf0", int'(ovf0), 0);
    chk("t3_pulses1", pc[1] - base1, 4);
    chk("t3_ovf1", int'(ovf1), 1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("t3_clr_ovf1", int'(ovf1), 0);

    // T4 overflow on the narrow counter
    base0 = pc[0]; base1 = pc[1]; peak[0] = 0; peak[1] = 0;
    pulse_din(6);
    chk("t4_peak1", peak[1], 3);
    chk("t4_peak0", peak[0], 5);
    chk("t4_ovf1", int'(ovf1), 1);
    cyc(500);
    chk("t4_pulses1", pc[1] - base1, 4);
    chk("t4_pulses0", pc[0] - base0, 6);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("t4_clr_ovf1", int'(ovf1), 0);

    // T5 launch and arrival in the same cycle, then set beating clear
    pulse_din(3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_fast);
      if (m_phase[0] == 0 && m_pend[0] == 2) found = 1'b1;
    end
    chk("t5_idle_reached", int'(found), 1);
    din = 1'b1; @(negedge clk_fast); din = 1'b0;
    chk("t5_pend0", int'(pend0), 2);
    chk("t5_pend1", int'(pend1), 2);
    chk("t5_busy1", int'(busy1), 1);
    din = 1'b1; @(negedge clk_fast);
    clr = 1'b1; @(negedge clk_fast);
    din = 1'b0; clr = 1'b0;
    chk("t5_ovf1", int'(ovf1), 1);
    chk("t5_pend1_sat", int'(pend1), 3);
    chk("t5_ovf0", int'(ovf0), 0);
    chk("t5_pend0_4", int'(pend0), 4);
    cyc(400);
    clr = 1'b1; cyc(1); clr = 1'b0;

    // T6 reset while waiting for ack
    base0 = pc[0];
    pulse_din(1);
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    chk("t6_pend0", int'(pend0), 0);
    chk("t6_busy0", int'(busy0), 0);
    rst_n = 1'b1;
    cyc(200);
    chk("t6_no_pulse0", pc[0] - base0, 0);
    pulse_din(1);
    cyc(150);
    chk("t6_one_pulse0", pc[0] - base0, 1);

    // Randomised traffic across several clock ratios, one reset per segment
    for (int s = 0; s < 4; s++) begin
      slow_half = halves[s];
      for (int i = 0; i < 1500; i++) begin
        pct = int'($urandom_range(0, 99));
        din = (pct < probs[s]);
        clr = (int'($urandom_range(0, 99)) < 3);
        if (i == 700) rst_n = 1'b0;
        if (i == 703) rst_n = 1'b1;
        @(negedge clk_fast);
      end
      din = 1'b0;
      clr = 1'b0;
      cyc(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
